// File: rtl/clk_switch_ctrl_if.sv
// Request/quiesce/select bundle between a switch requester and clk_switch_ctrl.
// The slave modport is the sequencer side; the master modport is the requester/downstream side.
interface clk_switch_ctrl_if;
  logic req_valid_i;
  logic req_sel_i;
  logic req_ready_o;
  logic quiesce_req_o;
  logic quiesce_ack_i;
  logic sel_o;
  logic cur_sel_o;
  logic busy_o;
  logic done_o;
  logic err_o;

  modport slave (
    input  req_valid_i, req_sel_i, quiesce_ack_i,
    output req_ready_o, quiesce_req_o, sel_o, cur_sel_o, busy_o, done_o, err_o
  );

  modport master (
    output req_valid_i, req_sel_i, quiesce_ack_i,
    input  req_ready_o, quiesce_req_o, sel_o, cur_sel_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock mux select sequencer: quiesce downstream, switch, settle, release.
// Runs on an always-on reference clock; the ack input is already synchronous to it.
module clk_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT   = 64,
  parameter bit          RESET_SEL     = 1'b0
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  clk_switch_ctrl_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST    = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit            ACK_TO_EN   = (ACK_TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, QUIESCE, SWITCH, RELEASE} state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic          target_reg;
  logic          sel_reg;
  logic          cur_sel_reg;
  logic          quiesce_req_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          err_reg;
  logic          ack_expired;

  // Shared by QUIESCE and RELEASE; the timer restarts at zero on every state entry.
  assign ack_expired = ACK_TO_EN && (timer_reg == ACK_LAST);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      target_reg      <= RESET_SEL;
      sel_reg         <= RESET_SEL;
      cur_sel_reg     <= RESET_SEL;
      quiesce_req_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid_i) begin
            // Requesting the already-committed source completes without touching the mux.
            if (bus.req_sel_i == cur_sel_reg) begin
              done_reg <= 1'b1;
            end else begin
              target_reg      <= bus.req_sel_i;
              state_reg       <= QUIESCE;
              quiesce_req_reg <= 1'b1;
              busy_reg        <= 1'b1;
              timer_reg       <= '0;
            end
          end
        end
        QUIESCE: begin
          if (bus.quiesce_ack_i) begin
            state_reg <= SWITCH;
            sel_reg   <= target_reg;
            timer_reg <= '0;
          end else if (ack_expired) begin
            state_reg       <= IDLE;
            quiesce_req_reg <= 1'b0;
            busy_reg        <= 1'b0;
            err_reg         <= 1'b1;
            timer_reg       <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        SWITCH: begin
          if (timer_reg == SETTLE_LAST) begin
            state_reg       <= RELEASE;
            cur_sel_reg     <= target_reg;
            quiesce_req_reg <= 1'b0;
            timer_reg       <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        RELEASE: begin
          // A release timeout leaves the new source committed; only the ack handshake failed.
          if (!bus.quiesce_ack_i) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            timer_reg <= '0;
          end else if (ack_expired) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b1;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = (state_reg == IDLE);
  assign bus.quiesce_req_o = quiesce_req_reg;
  assign bus.sel_o         = sel_reg;
  assign bus.cur_sel_o     = cur_sel_reg;
  assign bus.busy_o        = busy_reg;
  assign bus.done_o        = done_reg;
  assign bus.err_o         = err_reg;

endmodule
